// File: rtl/vram_arbiter.sv
// VRAM arbiter: one video fetch slot per 8-dot character (phase 6) and CPU request/ack access in every other cycle.
// Optional: define VRAM_ARB_BLANK_SKIP_EN to let the CPU take the video slot while vdp_visible=0.
module vram_arbiter #(
  parameter int AW = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [2:0]    dot,
  input  logic          vdp_visible,
  input  logic [AW-1:0] vdp_addr,
  output logic [7:0]    vdp_data,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [7:0]    cpu_wdata,
  output logic          cpu_ack,
  output logic [7:0]    cpu_rdata,
  output logic [AW-1:0] ram_addr,
  output logic          ram_we,
  output logic [7:0]    ram_wdata,
  input  logic [7:0]    ram_rdata
);

  // state    | meaning
  // ST_IDLE  | no CPU access in flight, waiting for cpu_req
  // ST_SLOT  | CPU command is on the RAM pins
  // ST_WAIT  | RAM read data valid, capture it and raise ack
  // ST_ACK   | cpu_ack high for this single cycle
  typedef enum logic [1:0] {ST_IDLE, ST_SLOT, ST_WAIT, ST_ACK} state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] ram_addr_q, ram_addr_d;
  logic          ram_we_q, ram_we_d;
  logic [7:0]    ram_wdata_q, ram_wdata_d;
  logic          cpu_ack_q, cpu_ack_d;
  logic [7:0]    cpu_rdata_q, cpu_rdata_d;
  logic [7:0]    vdp_data_q, vdp_data_d;
  logic          op_we_q, op_we_d;
  logic          vid_fetch_q, vid_fetch_d;
  logic          vid_take;

`ifdef VRAM_ARB_BLANK_SKIP_EN
  assign vid_take = (dot == 3'd5) && vdp_visible;
`else
  logic unused_visible;
  assign unused_visible = vdp_visible;
  assign vid_take       = (dot == 3'd5);
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      ram_addr_q  <= '0;
      ram_we_q    <= 1'b0;
      ram_wdata_q <= 8'h00;
      cpu_ack_q   <= 1'b0;
      cpu_rdata_q <= 8'h00;
      vdp_data_q  <= 8'h00;
      op_we_q     <= 1'b0;
      vid_fetch_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ram_addr_q  <= ram_addr_d;
      ram_we_q    <= ram_we_d;
      ram_wdata_q <= ram_wdata_d;
      cpu_ack_q   <= cpu_ack_d;
      cpu_rdata_q <= cpu_rdata_d;
      vdp_data_q  <= vdp_data_d;
      op_we_q     <= op_we_d;
      vid_fetch_q <= vid_fetch_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    ram_addr_d  = ram_addr_q;
    ram_we_d    = 1'b0;
    ram_wdata_d = ram_wdata_q;
    cpu_ack_d   = 1'b0;
    cpu_rdata_d = cpu_rdata_q;
    vdp_data_d  = vdp_data_q;
    op_we_d     = op_we_q;
    vid_fetch_d = vid_fetch_q;

    // Remember whether the phase-6 slot fetched video, so phase 7 knows what to load.
    if (dot == 3'd5) begin
      vid_fetch_d = vid_take;
    end
    if (vid_take) begin
      ram_addr_d = vdp_addr;
    end
    if (dot == 3'd7) begin
      vdp_data_d = vid_fetch_q ? ram_rdata : 8'h00;
    end

    case (state_q)
      ST_IDLE: begin
        if (cpu_req && !vid_take) begin
          ram_addr_d  = cpu_addr;
          ram_we_d    = cpu_we;
          ram_wdata_d = cpu_wdata;
          op_we_d     = cpu_we;
          state_d     = ST_SLOT;
        end
      end
      ST_SLOT: state_d = ST_WAIT;
      ST_WAIT: begin
        if (!op_we_q) begin
          cpu_rdata_d = ram_rdata;
        end
        cpu_ack_d = 1'b1;
        state_d   = ST_ACK;
      end
      ST_ACK:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign vdp_data  = vdp_data_q;
  assign cpu_ack   = cpu_ack_q;
  assign cpu_rdata = cpu_rdata_q;
  assign ram_addr  = ram_addr_q;
  assign ram_we    = ram_we_q;
  assign ram_wdata = ram_wdata_q;

endmodule

// File: doc/vram_arbiter.md
# vram_arbiter

Shares one synchronous single-port video RAM between the VDP scanout fetch and a CPU-side request/acknowledge port. Time is divided into 8-cycle character slots locked to the VDP dot phase. One fixed slot per character is reserved for the video fetch, and every other cycle can carry a CPU access. The block sits between the VDP, the CPU bus bridge and the VRAM macro, and presents the VDP with a byte that is stable for a whole character.

## Interface
Parameters:
- `AW`, default 16: VRAM address width.

Ports:
- `clk`  in  1  dot clock, rising-edge.
- `reset`  in  1  asynchronous, active-low. Asserted when 0.
- `dot`  in  3  current dot phase within the character (0..7), from the VGA timing.
- `vdp_visible`  in  1  high while the character being fetched lies in the visible area.
- `vdp_addr`  in  AW  address of the *next* character to display. Must be stable during phase 5.
- `vdp_data`  out  8  byte for the current character. Registered; changes only at phase 0.
- `cpu_req`  in  1  access request, held until `cpu_ack` is seen.
- `cpu_we`  in  1  1 = write, 0 = read. Held with `cpu_req`.
- `cpu_addr`  in  AW  access address. Held with `cpu_req`.
- `cpu_wdata`  in  8  write data. Held with `cpu_req`.
- `cpu_ack`  out  1  one-cycle completion pulse.
- `cpu_rdata`  out  8  read data. Valid while `cpu_ack` is high and held until the next ack.
- `ram_addr`  out  AW  registered RAM address.
- `ram_we`  out  1  registered RAM write strobe.
- `ram_wdata`  out  8  registered RAM write data.
- `ram_rdata`  in  8  RAM read data. Valid the cycle after the slot that addressed it.

## Operation
- **Slot:** a slot is the cycle in which `ram_*` holds a command. The command is decided from the inputs in the preceding cycle.
- **Video slot:** phase 6.
  - Decided in the phase-5 cycle: `ram_addr<=vdp_addr`, `ram_we<=0`.
  - `ram_rdata` is valid in phase 7 and is captured into `vdp_data` at the end of phase 7.
  - `vdp_data` is therefore new from phase 0.
- **Video priority:** the video slot always wins. The CPU never issues a command from a phase-5 decision cycle.
- **CPU state machine:** IDLE → SLOT → WAIT → ACK → IDLE.
  - **IDLE:** if `cpu_req=1` and `dot!=5`, register `cpu_addr`, `cpu_we` and `cpu_wdata` onto `ram_*` and go to SLOT. Otherwise stay in IDLE.
  - **SLOT:** the command is on the RAM. Go to WAIT.
  - **WAIT:** capture `ram_rdata` into `cpu_rdata` (reads only; writes leave `cpu_rdata` unchanged), set `cpu_ack<=1`, go to ACK.
  - **ACK:** `cpu_ack` is high for exactly this cycle. `cpu_req` is ignored. Go to IDLE.
- **Handshake:** the requester must hold its signals until it sees ack, then drop or change them by the cycle after ack. A request still held in the IDLE cycle after ACK is treated as a new access.
- **Idle bus:** when no command is issued for a cycle, `ram_we<=0` and `ram_addr` keeps its last value.
- **Reset (`reset=0`, any time):**
  - State returns to IDLE.
  - `cpu_ack=0`, `cpu_rdata=0`, `vdp_data=0`.
  - `ram_addr=0`, `ram_we=0`, `ram_wdata=0`.
  - An in-flight CPU access is dropped with no ack. The requester must re-issue after reset is released.
- **Width:** `dot` arithmetic is modulo 8. No other arithmetic is performed.

## Timing
- **CPU latency:** request sampled in IDLE at cycle T (`dot!=5`) → slot at T+1 → `cpu_ack` at T+3.
  - If T falls on phase 5, issue slips one cycle and the ack arrives at T+4.
- **CPU throughput:** at most one access per 4 cycles.
- **Video latency:** `vdp_addr` sampled at phase 5 → displayed at the next phase 0, 3 cycles later.
- **Write visibility:** a CPU write is committed in its slot. A video fetch of the same address in a later slot returns the new byte.
- **Same-cycle request and phase 5:** the video fetch takes the slot and the CPU request is deferred. Neither is lost.

## Configuration
- **`VRAM_ARB_BLANK_SKIP_EN` defined:** if `vdp_visible=0` in the phase-5 decision cycle:
  - no video command is issued;
  - `vdp_data` loads 0x00 at the end of phase 7;
  - the CPU may use phase 5 as a decision cycle (its command takes the phase-6 slot).
- **Not defined:** the video slot is taken every character and `vdp_visible` is ignored.

## Test plan
- **Reset:** hold `reset=0` mid-access, release it → all outputs 0, no `cpu_ack`, state IDLE.
- **Video only:** RAM preloaded `mem[0x1234]=0xA5`, `vdp_addr=0x1234` at phase 5, no CPU traffic → `ram_addr=0x1234` at phase 6, `vdp_data=0xA5` from the next phase 0 through phase 7.
- **CPU write then read:** write 0x3C to 0x0100 with `cpu_req` raised at phase 1, then read 0x0100 → each ack arrives 3 cycles after its sampling cycle, `cpu_rdata=0x3C`, exactly one ack per request.
- **Collision:** `cpu_req` first sampled at phase 5 → CPU slot lands at phase 7 and the ack arrives 4 cycles later. The concurrent `vdp_data` fetch is correct.
- **Coherence:** CPU writes 0x77 to the address the video fetches at the following phase 6 → `vdp_data=0x77` at the next phase 0.
- **Blank skip:** with `VRAM_ARB_BLANK_SKIP_EN` defined and `vdp_visible=0`, a request sampled at phase 5 → CPU slot at phase 6, no video command issued, `vdp_data=0x00`. Without the macro, the same stimulus → video fetch at phase 6 and CPU slot at phase 7.
